// File: rtl/eblade_stream_pkg.sv
// Shared stream-scheduler definitions: FSM state encoding and default geometry.
package eblade_stream_pkg;

    localparam int unsigned N_CH_DEFAULT   = 4;
    localparam int unsigned DATA_W_DEFAULT = 8;

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_PKT = 1'b1
    } sched_state_e;

endpackage : eblade_stream_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requester strictly after last_grant, wrapping.
module rr_arbiter
    import eblade_stream_pkg::*;
#(
    parameter  int unsigned N_CH = N_CH_DEFAULT,
    localparam int unsigned CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last_grant,
    output logic [CH_W-1:0] next_idx_c,
    output logic            any_req_c
);

    // One extra bit holds last_grant + 1 + i (at most 2*N_CH-1) before the wrap.
    localparam int unsigned IW = CH_W + 1;

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        next_idx_c = last_grant;
        found      = 1'b0;
        cand       = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cand = IW'(last_grant) + IW'(i) + IW'(1);
            if (cand >= IW'(N_CH)) begin
                cand = cand - IW'(N_CH);
            end
            if (!found && req[cand[CH_W-1:0]]) begin
                found      = 1'b1;
                next_idx_c = cand[CH_W-1:0];
            end
        end
    end

    assign any_req_c = |req;

endmodule : rr_arbiter

// File: rtl/rr_pkt_scheduler.sv
// Packet-granular round-robin stream scheduler: locks a channel for a whole packet,
// forwards its beats through a single output register, then re-arbitrates.
module rr_pkt_scheduler
    import eblade_stream_pkg::*;
#(
    parameter  int unsigned N_CH   = N_CH_DEFAULT,
    parameter  int unsigned DATA_W = DATA_W_DEFAULT,
    localparam int unsigned CH_W   = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] tdata_i,
    input  logic [N_CH-1:0]        tvalid_i,
    input  logic [N_CH-1:0]        tlast_i,
    output logic [N_CH-1:0]        tready_i,
    output logic [DATA_W-1:0]      tdata_o,
    output logic                   tvalid_o,
    output logic                   tlast_o,
    input  logic                   tready_o,
    output logic [CH_W-1:0]        grant_o,
    output logic                   busy_o
);

    sched_state_e      state_q;
    sched_state_e      state_d;
    logic [CH_W-1:0]   grant_d;
    logic [DATA_W-1:0] data_d;
    logic              vld_d;
    logic              last_d;
    logic              accept;
    logic              out_free;
    logic [CH_W-1:0]   next_idx_c;
    logic              any_req_c;
    logic [DATA_W-1:0] ch_data [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        assign ch_data[g] = tdata_i[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req        (tvalid_i),
        .last_grant (grant_o),
        .next_idx_c (next_idx_c),
        .any_req_c  (any_req_c)
    );

    // Output register can take a beat when empty or being drained this cycle.
    assign out_free = ~tvalid_o | tready_o;

    // Next-state, ready demux and output-register update.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_o;
        data_d   = tdata_o;
        vld_d    = tvalid_o;
        last_d   = tlast_o;
        tready_i = '0;
        accept   = 1'b0;

        case (state_q)
            ST_ARB: begin
                if (any_req_c) begin
                    grant_d = next_idx_c;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                tready_i[grant_o] = out_free;
                accept            = tvalid_i[grant_o] & out_free;
                if (accept && tlast_i[grant_o]) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase

        // The final beat of a packet still drains while the FSM sits in ARB.
        if (accept) begin
            vld_d  = 1'b1;
            data_d = ch_data[grant_o];
            last_d = tlast_i[grant_o];
        end else if (tready_o) begin
            vld_d = 1'b0;
        end
    end

    // Reset parks the grant on the last channel so channel 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ARB;
            grant_o  <= CH_W'(N_CH - 1);
            tdata_o  <= '0;
            tvalid_o <= 1'b0;
            tlast_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_o  <= grant_d;
            tdata_o  <= data_d;
            tvalid_o <= vld_d;
            tlast_o  <= last_d;
            busy_o   <= (state_d == ST_PKT);
        end
    end

endmodule : rr_pkt_scheduler

// File: tb/tb_rr_pkt_scheduler.sv
// Directed bench for rr_pkt_scheduler: 4-channel/8-bit instance plus a 2-channel/32-bit one.
module tb_rr_pkt_scheduler;

    logic        clk;
    logic        rst;

    logic [31:0] tdata_i;
    logic [3:0]  tvalid_i;
    logic [3:0]  tlast_i;
    logic [3:0]  tready_i;
    logic [7:0]  tdata_o;
    logic        tvalid_o;
    logic        tlast_o;
    logic        tready_o;
    logic [1:0]  grant_o;
    logic        busy_o;

    logic [63:0] tdata2_i;
    logic [1:0]  tvalid2_i;
    logic [1:0]  tlast2_i;
    logic [1:0]  tready2_i;
    logic [31:0] tdata2_o;
    logic        tvalid2_o;
    logic        tlast2_o;
    logic        tready2_o;
    logic [0:0]  grant2_o;
    logic        busy2_o;

    // Per-channel beat sources: {last, data}
    logic [8:0]  mem [4][8];
    logic [2:0]  cnt [4];
    logic [2:0]  ptr [4];
    logic        en  [4];
    int          ptr2;
    int          cnt2;

    int n_assert;
    int n_fail;

    rr_pkt_scheduler #(.N_CH(4), .DATA_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .tdata_i  (tdata_i),
        .tvalid_i (tvalid_i),
        .tlast_i  (tlast_i),
        .tready_i (tready_i),
        .tdata_o  (tdata_o),
        .tvalid_o (tvalid_o),
        .tlast_o  (tlast_o),
        .tready_o (tready_o),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    rr_pkt_scheduler #(.N_CH(2), .DATA_W(32)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .tdata_i  (tdata2_i),
        .tvalid_i (tvalid2_i),
        .tlast_i  (tlast2_i),
        .tready_i (tready2_i),
        .tdata_o  (tdata2_o),
        .tvalid_o (tvalid2_o),
        .tlast_o  (tlast2_o),
        .tready_o (tready2_o),
        .grant_o  (grant2_o),
        .busy_o   (busy2_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // {busy, grant, valid, last, data}; last/data only meaningful while valid
    function automatic logic [63:0] exp1(input bit b, input int g, input bit v, input bit l, input int d);
        return 64'({b, 2'(g), v, v & l, v ? 8'(d) : 8'h00});
    endfunction

    function automatic logic [63:0] obs1();
        return 64'({busy_o, grant_o, tvalid_o, tvalid_o & tlast_o, tvalid_o ? tdata_o : 8'h00});
    endfunction

    function automatic logic [63:0] exp2(input bit b, input int g, input bit v, input bit l, input logic [31:0] d);
        return 64'({b, 1'(g), v, v & l, v ? d : 32'h0});
    endfunction

    function automatic logic [63:0] obs2();
        return 64'({busy2_o, grant2_o, tvalid2_o, tvalid2_o & tlast2_o, tvalid2_o ? tdata2_o : 32'h0});
    endfunction

    task automatic drive();
        logic [7:0] td [4];
        logic [3:0] v;
        logic [3:0] l;
        for (logic [2:0] k = 0; k < 4; k++) begin
            td[k[1:0]] = 8'h00;
            v[k[1:0]]  = 1'b0;
            l[k[1:0]]  = 1'b0;
            if (en[k[1:0]] && ptr[k[1:0]] < cnt[k[1:0]]) begin
                td[k[1:0]] = mem[k[1:0]][ptr[k[1:0]]][7:0];
                v[k[1:0]]  = 1'b1;
                l[k[1:0]]  = mem[k[1:0]][ptr[k[1:0]]][8];
            end
        end
        tdata_i  = {td[3], td[2], td[1], td[0]};
        tvalid_i = v;
        tlast_i  = l;
        tvalid2_i = {(ptr2 < cnt2), 1'b0};
        tlast2_i  = 2'b10;
        tdata2_i  = {32'hCAFE_0000 + 32'(ptr2), 32'h0};
    endtask

    // One clock: sample handshakes mid-cycle, advance sources after the edge.
    task automatic step();
        logic [3:0] hs;
        logic       hs2;
        @(negedge clk);
        hs  = tvalid_i & tready_i;
        hs2 = tvalid2_i[1] & tready2_i[1];
        @(posedge clk);
        #1;
        for (logic [2:0] k = 0; k < 4; k++) begin
            if (hs[k[1:0]]) ptr[k[1:0]] = ptr[k[1:0]] + 3'd1;
        end
        if (hs2) ptr2++;
        drive();
    endtask

    task automatic sc(input string tag, input bit b, input int g, input bit v, input bit l, input int d);
        step();
        chk(tag, obs1(), exp1(b, g, v, l, d));
    endtask

    task automatic sc2(input string tag, input bit b, input int g, input bit v, input logic [31:0] d);
        step();
        chk(tag, obs2(), exp2(b, g, v, 1'b1, d));
    endtask

    task automatic chk_rst(input string tag);
        chk(tag, 64'({busy_o, grant_o, tvalid_o, tlast_o, tdata_o, tready_i}),
            64'({1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 4'h0}));
    endtask

    task automatic clear_src();
        for (logic [2:0] k = 0; k < 4; k++) begin
            cnt[k[1:0]] = 3'd0;
            ptr[k[1:0]] = 3'd0;
            en[k[1:0]]  = 1'b1;
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_src();
        drive();
        @(posedge clk);
        #1;
        chk_rst(tag);
        rst = 1'b1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        tready_o  = 1'b1;
        tready2_o = 1'b1;
        ptr2      = 0;
        cnt2      = 0;
        clear_src();
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk_rst("reset_state");
        chk("reset_state_n2", obs2(), exp2(1'b0, 1, 1'b0, 1'b0, 32'h0));
        rst = 1'b1;

        // ch0 and ch2 each one 3-beat packet
        mem[0][0] = 9'h010; mem[0][1] = 9'h011; mem[0][2] = 9'h112; cnt[0] = 3'd3;
        mem[2][0] = 9'h030; mem[2][1] = 9'h031; mem[2][2] = 9'h132; cnt[2] = 3'd3;
        drive();
        sc("two_pkt_arb0", 1'b1, 0, 1'b0, 1'b0, 0);
        chk("two_pkt_ready", 64'(tready_i), 64'(4'b0001));
        sc("two_pkt_b0",   1'b1, 0, 1'b1, 1'b0, 8'h10);
        sc("two_pkt_b1",   1'b1, 0, 1'b1, 1'b0, 8'h11);
        sc("two_pkt_b2",   1'b0, 0, 1'b1, 1'b1, 8'h12);
        chk("arb_ready_low", 64'(tready_i), 64'(4'b0000));
        sc("two_pkt_arb2", 1'b1, 2, 1'b0, 1'b0, 0);
        sc("two_pkt_c0",   1'b1, 2, 1'b1, 1'b0, 8'h30);
        sc("two_pkt_c1",   1'b1, 2, 1'b1, 1'b0, 8'h31);
        sc("two_pkt_c2",   1'b0, 2, 1'b1, 1'b1, 8'h32);
        sc("two_pkt_idle", 1'b0, 2, 1'b0, 1'b0, 0);

        // all four channels continuously valid, 2-beat packets
        do_reset("reset_rr");
        for (int k = 0; k < 4; k++) begin
            mem[k][0] = {1'b0, 4'(k), 4'h0};
            mem[k][1] = {1'b1, 4'(k), 4'h1};
            mem[k][2] = {1'b0, 4'(k), 4'h2};
            mem[k][3] = {1'b1, 4'(k), 4'h3};
            cnt[k]    = 3'd4;
        end
        drive();
        for (int p = 0; p < 5; p++) begin
            sc($sformatf("rr_p%0d_arb", p), 1'b1, p % 4, 1'b0, 1'b0, 0);
            sc($sformatf("rr_p%0d_b0", p),  1'b1, p % 4, 1'b1, 1'b0, {4'(p % 4), 4'(2 * (p / 4))});
            sc($sformatf("rr_p%0d_b1", p),  1'b0, p % 4, 1'b1, 1'b1, {4'(p % 4), 4'(2 * (p / 4) + 1)});
        end

        // ch1 4-beat packet under downstream backpressure 1,0,0,1,...
        do_reset("reset_bp");
        mem[1][0] = 9'h0A0; mem[1][1] = 9'h0A1; mem[1][2] = 9'h0A2; mem[1][3] = 9'h1A3; cnt[1] = 3'd4;
        drive();
        tready_o = 1'b1; sc("bp_s1", 1'b1, 1, 1'b0, 1'b0, 0);
        tready_o = 1'b0; sc("bp_s2", 1'b1, 1, 1'b1, 1'b0, 8'hA0);
        tready_o = 1'b0; sc("bp_s3", 1'b1, 1, 1'b1, 1'b0, 8'hA0);
        chk("bp_stall_ready", 64'(tready_i), 64'(4'b0000));
        tready_o = 1'b1; sc("bp_s4", 1'b1, 1, 1'b1, 1'b0, 8'hA1);
        tready_o = 1'b1; sc("bp_s5", 1'b1, 1, 1'b1, 1'b0, 8'hA2);
        tready_o = 1'b0; sc("bp_s6", 1'b1, 1, 1'b1, 1'b0, 8'hA2);
        tready_o = 1'b0; sc("bp_s7", 1'b1, 1, 1'b1, 1'b0, 8'hA2);
        tready_o = 1'b1; sc("bp_s8", 1'b0, 1, 1'b1, 1'b1, 8'hA3);
        tready_o = 1'b1; sc("bp_s9", 1'b0, 1, 1'b0, 1'b0, 0);
        chk("bp_all_taken", 64'(ptr[1]), 64'(3'd4));

        // ch3 drops valid mid-packet for 5 cycles while ch0 waits
        do_reset("reset_hold");
        mem[3][0] = 9'h0D0; mem[3][1] = 9'h0D1; mem[3][2] = 9'h1D2; cnt[3] = 3'd3;
        mem[0][0] = 9'h150; cnt[0] = 3'd1;
        en[0] = 1'b0;
        drive();
        sc("hold_arb3", 1'b1, 3, 1'b0, 1'b0, 0);
        en[0] = 1'b1;
        drive();
        sc("hold_d0", 1'b1, 3, 1'b1, 1'b0, 8'hD0);
        en[3] = 1'b0;
        drive();
        for (int i = 0; i < 5; i++) begin
            sc($sformatf("hold_gap%0d", i), 1'b1, 3, 1'b0, 1'b0, 0);
        end
        en[3] = 1'b1;
        drive();
        sc("hold_d1",   1'b1, 3, 1'b1, 1'b0, 8'hD1);
        sc("hold_d2",   1'b0, 3, 1'b1, 1'b1, 8'hD2);
        sc("hold_arb0", 1'b1, 0, 1'b0, 1'b0, 0);
        sc("hold_ch0",  1'b0, 0, 1'b1, 1'b1, 8'h50);

        // asynchronous reset during beat 2 of a ch1 packet
        do_reset("reset_mid");
        mem[1][0] = 9'h0B0; mem[1][1] = 9'h0B1; mem[1][2] = 9'h0B2; mem[1][3] = 9'h1B3; cnt[1] = 3'd4;
        drive();
        sc("mid_arb1", 1'b1, 1, 1'b0, 1'b0, 0);
        sc("mid_b0",   1'b1, 1, 1'b1, 1'b0, 8'hB0);
        #2;
        rst = 1'b0;
        #1;
        chk_rst("mid_async_rst");
        step();
        chk_rst("mid_rst_next");
        rst = 1'b1;
        ptr[1] = 3'd0; cnt[1] = 3'd1; mem[1][0] = 9'h1E0;
        ptr[2] = 3'd0; cnt[2] = 3'd1; mem[2][0] = 9'h1C0;
        drive();
        sc("post_arb1", 1'b1, 1, 1'b0, 1'b0, 0);
        sc("post_e0",   1'b0, 1, 1'b1, 1'b1, 8'hE0);
        sc("post_arb2", 1'b1, 2, 1'b0, 1'b0, 0);
        sc("post_c0",   1'b0, 2, 1'b1, 1'b1, 8'hC0);

        // 2-channel/32-bit instance: lone ch1 with single-beat packets
        ptr2 = 0;
        cnt2 = 3;
        drive();
        sc2("n2_arb_a", 1'b1, 1, 1'b0, 32'h0);
        sc2("n2_w0",    1'b0, 1, 1'b1, 32'hCAFE_0000);
        sc2("n2_arb_b", 1'b1, 1, 1'b0, 32'h0);
        sc2("n2_w1",    1'b0, 1, 1'b1, 32'hCAFE_0001);
        sc2("n2_arb_c", 1'b1, 1, 1'b0, 32'h0);
        sc2("n2_w2",    1'b0, 1, 1'b1, 32'hCAFE_0002);
        sc2("n2_idle",  1'b0, 1, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rr_pkt_scheduler
